// File: rtl/dict_word_matcher.sv
// dict_word_matcher
//   Dictionary search engine sitting between the processor and DictMem.
//   A start request latches a key and a compare mask, then the engine walks
//   DictMem from address 0 upward. Each 32-bit entry is compared against the
//   key under the mask until one of these happens:
//   - a hit is found;
//   - the end-of-dictionary sentinel word is read;
//   - the last address (DEPTH-1) has been examined.
//   The result is reported with a one-cycle done pulse.
//
// Ports
//   clock            in   1   system clock, all state changes on posedge
//   reset            in   1   asynchronous, active-high, clears all state
//   start            in   1   request pulse, honoured only in IDLE or DONE
//   key              in   32  word to find, latched on accepted start
//   mask             in   32  compare mask, latched on accepted start
//   busy             out  1   scan in progress
//   done             out  1   one-cycle result-valid pulse
//   found            out  1   1 = hit, 0 = miss, held until next accepted start
//   match_index      out  12  hit address (0 on miss), held likewise
//   address_dictmem  out  32  registered DictMem address, upper bits zero
//   q_dictmem        in   32  DictMem read data, one-cycle registered read
module dict_word_matcher #(
  parameter int          DEPTH  = 4096,
  parameter int          ADDR_W = 12,
  parameter logic [31:0] TERM   = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       key,
  input  logic [31:0]       mask,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] match_index,
  output logic [31:0]       address_dictmem,
  input  logic [31:0]       q_dictmem
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t              state;
  logic [31:0]         key_r;
  logic [31:0]         mask_r;
  logic [ADDR_W-1:0]   addr_p0;
  logic [ADDR_W-1:0]   idx_p1;
  logic                vld_p1;

  // Only bits selected by the mask take part in the comparison.
  function automatic logic masked_eq(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input logic [31:0] m);
    return ((a ^ b) & m) == 32'h0;
  endfunction

  assign address_dictmem = {{(32 - ADDR_W){1'b0}}, addr_p0};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      key_r       <= '0;
      mask_r      <= '0;
      addr_p0     <= '0;
      idx_p1      <= '0;
      vld_p1      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      match_index <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            key_r       <= key;
            mask_r      <= mask;
            addr_p0     <= '0;
            vld_p1      <= 1'b0;
            found       <= 1'b0;
            match_index <= '0;
            busy        <= 1'b1;
            state       <= S_SCAN;
          end else if (state == S_DONE) begin
            state <= S_IDLE;
          end
        end

        S_SCAN: begin
          // Stage p1: q_dictmem holds entry idx_p1 whenever vld_p1 is set.
          // The sentinel is checked unmasked and takes priority over a hit.
          if (vld_p1 && (q_dictmem == TERM)) begin
            found       <= 1'b0;
            match_index <= '0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_DONE;
          end else if (vld_p1 && masked_eq(q_dictmem, key_r, mask_r)) begin
            found       <= 1'b1;
            match_index <= idx_p1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_DONE;
          end else if (vld_p1 && (idx_p1 == LAST_ADDR)) begin
            found       <= 1'b0;
            match_index <= '0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_DONE;
          end else begin
            // Stage p0: address runs ahead of the compare by one read latency
            // and parks on the last entry rather than wrapping to 0.
            if (addr_p0 < LAST_ADDR) begin
              addr_p0 <= addr_p0 + 1'b1;
            end
            idx_p1 <= addr_p0;
            vld_p1 <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dict_word_matcher.sv
module tb_dict_word_matcher;

  localparam int          DEPTH = 16;
  localparam logic [31:0] TERM  = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] key   = '0;
  logic [31:0] mask  = '0;
  logic        busy;
  logic        done;
  logic        found;
  logic [11:0] match_index;
  logic [31:0] address_dictmem;
  logic [31:0] q_dictmem = '0;

  logic [31:0] rom [0:4095];

  int checks = 0;
  int errors = 0;

  // Expected outputs, as seen after each posedge.
  logic        exp_busy  = 1'b0;
  logic        exp_done  = 1'b0;
  logic        exp_found = 1'b0;
  logic [11:0] exp_idx   = '0;
  logic [31:0] exp_addr  = '0;
  bit          m_active  = 1'b0;
  int          m_k       = 0;
  int          m_i       = 0;
  bit          m_hit     = 1'b0;
  logic [31:0] max_addr  = '0;

  dict_word_matcher #(.DEPTH(DEPTH), .ADDR_W(12), .TERM(TERM)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .key             (key),
    .mask            (mask),
    .busy            (busy),
    .done            (done),
    .found           (found),
    .match_index     (match_index),
    .address_dictmem (address_dictmem),
    .q_dictmem       (q_dictmem)
  );

  always #5 clock = ~clock;

  // DictMem: one-cycle registered read.
  always @(posedge clock) q_dictmem <= rom[address_dictmem[11:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference search: first index that terminates the scan, and whether it hit.
  function automatic void ref_scan(input logic [31:0] k, input logic [31:0] m,
                                   output int idx, output bit hit);
    hit = 1'b0;
    idx = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (rom[i] == TERM) begin
        idx = i;
        return;
      end
      if (((rom[i] ^ k) & m) == 32'h0) begin
        idx = i;
        hit = 1'b1;
        return;
      end
    end
  endfunction

  // Behavioural model: on acceptance the whole outcome is known; afterwards
  // just count edges to the done edge (index + 2).
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active  = 1'b0;
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      exp_found = 1'b0;
      exp_idx   = '0;
      exp_addr  = '0;
    end else if (m_active) begin
      m_k++;
      if (m_k == m_i + 2) begin
        exp_done  = 1'b1;
        exp_busy  = 1'b0;
        exp_found = m_hit;
        exp_idx   = m_hit ? 12'(m_i) : 12'd0;
        m_active  = 1'b0;
      end else begin
        exp_done = 1'b0;
        exp_addr = (m_k < DEPTH - 1) ? 32'(m_k) : 32'(DEPTH - 1);
      end
    end else if (start) begin
      ref_scan(key, mask, m_i, m_hit);
      m_active  = 1'b1;
      m_k       = 0;
      exp_busy  = 1'b1;
      exp_done  = 1'b0;
      exp_found = 1'b0;
      exp_idx   = '0;
      exp_addr  = '0;
    end else begin
      exp_done = 1'b0;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("found", 32'(found), 32'(exp_found));
    chk("match_index", 32'(match_index), 32'(exp_idx));
    chk("address", address_dictmem, exp_addr);
    if (address_dictmem > max_addr) max_addr = address_dictmem;
  end

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 32'h0;
  endtask

  // Issue a request; returns edges from accept edge to done edge (0 on timeout).
  // If inject > 0, a stray start with a different key is pulsed mid-scan.
  task automatic run_req(input logic [31:0] k, input logic [31:0] m,
                         input int inject, input logic [31:0] inj_key,
                         output int edges);
    bit got = 1'b0;
    key   = k;
    mask  = m;
    start = 1'b1;
    @(posedge clock);
    #2 start = 1'b0;
    edges = 0;
    while (edges < 60 && !got) begin
      @(posedge clock);
      edges++;
      #1;
      if (done) got = 1'b1;
      else begin
        #1;
        start = (edges == inject);
        if (edges == inject) key = inj_key;
      end
    end
    start = 1'b0;
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      edges = 0;
    end
  endtask

  function automatic logic [31:0] rnd_word();
    if ($urandom_range(0, 11) == 0) return TERM;
    return 32'h4100_4100 | (32'($urandom_range(0, 3)) << 16) | 32'($urandom_range(0, 3));
  endfunction

  int e;

  initial begin
    clear_rom();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_idx", 32'(match_index), 32'd0);
    chk("rst_addr", address_dictmem, 32'd0);
    #1 reset = 1'b0;
    @(posedge clock);
    #2;

    // T1 + T4: hit at 5, stray start mid-scan is ignored.
    rom[0] = 32'h4141_4141; rom[1] = 32'h4242_4242; rom[2] = 32'h4343_4343;
    rom[3] = 32'h4444_4444; rom[4] = 32'h4545_4545; rom[5] = 32'h4B4B_4B4B;
    rom[6] = 32'h4747_4747; rom[7] = 32'h0;
    run_req(32'h4B4B_4B4B, 32'hFFFF_FFFF, 3, 32'h4141_4141, e);
    chk("t1_edges", 32'(e), 32'd7);
    chk("t1_found", 32'(found), 32'd1);
    chk("t1_idx", 32'(match_index), 32'd5);
    chk("t1_busy", 32'(busy), 32'd0);
    // Start in the DONE cycle is accepted.
    #1;
    key   = 32'h4343_4343;
    start = 1'b1;
    @(posedge clock);
    #1;
    chk("t4_busy_next", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (6) @(posedge clock);
    #2;

    // T2: terminator at 3, miss.
    clear_rom();
    rom[0] = 32'h4141_4141; rom[1] = 32'h4242_4242; rom[2] = 32'h4343_4343;
    max_addr = '0;
    run_req(32'h5A5A_5A5A, 32'hFFFF_FFFF, 0, 32'h0, e);
    chk("t2_edges", 32'(e), 32'd5);
    chk("t2_found", 32'(found), 32'd0);
    chk("t2_idx", 32'(match_index), 32'd0);
    chk("t2_addr_max", 32'(max_addr <= 32'd4), 32'd1);
    repeat (2) @(posedge clock);
    #2;

    // T5: no terminator, no match, scan ends at DEPTH-1.
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'h5000_0000 + 32'(i) + 32'd1;
    run_req(32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 32'h0, e);
    chk("t5_edges", 32'(e), 32'd17);
    chk("t5_found", 32'(found), 32'd0);
    chk("t5_addr", address_dictmem, 32'd15);
    repeat (2) @(posedge clock);
    #2;

    // T6: reset three edges into a scan.
    key   = 32'hDEAD_BEEF;
    mask  = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clock);
    #2 start = 1'b0;
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_found", 32'(found), 32'd0);
    chk("t6_idx", 32'(match_index), 32'd0);
    chk("t6_addr", address_dictmem, 32'd0);
    @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock);
    #2;

    // T3: masked prefix match after reset.
    clear_rom();
    rom[0] = 32'h6163_7A7A; rom[1] = 32'h7862_0000; rom[2] = 32'h6162_7A7A;
    run_req(32'h6162_0000, 32'hFFFF_0000, 0, 32'h0, e);
    chk("t3_edges", 32'(e), 32'd4);
    chk("t3_found", 32'(found), 32'd1);
    chk("t3_idx", 32'(match_index), 32'd2);
    @(posedge clock);
    #2;

    // mask==0: first non-terminator entry hits.
    run_req(32'h1234_5678, 32'h0, 0, 32'h0, e);
    chk("mask0_idx", 32'(match_index), 32'd0);
    chk("mask0_found", 32'(found), 32'd1);
    @(posedge clock);
    #2;

    // Randomized traffic checked every cycle by the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!m_active) begin
        for (int i = 0; i < DEPTH; i++) rom[i] = rnd_word();
      end
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: mask = 32'hFFFF_FFFF;
        1: mask = 32'h0000_FFFF;
        2: mask = 32'hFFFF_0000;
        3: mask = 32'h0;
        default: mask = $urandom();
      endcase
      key = ($urandom_range(0, 1) == 0) ? rom[$urandom_range(0, DEPTH - 1)] : rnd_word() ^ 32'h0000_0100;
      if ($urandom_range(0, 99) == 0) begin
        #1 reset = 1'b1;
        @(posedge clock);
        #3 reset = 1'b0;
      end
      @(posedge clock);
      #2;
    end
    start = 1'b0;
    repeat (3) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
